// File: rtl/fpu_mul_seq_if.sv
// Request/response bundle between the FPU front-end (master) and the fmul responder (slave).
interface fpu_mul_seq_if;
  logic [7:0]  opcode;
  logic [31:0] x1;
  logic [31:0] x2;
  logic [31:0] y;
  logic        ovf;
  logic        unf;
  logic        out_valid;

  modport master (output opcode, x1, x2, input  y, ovf, unf, out_valid);
  modport slave  (input  opcode, x1, x2, output y, ovf, unf, out_valid);
endinterface

// File: rtl/fpu_mul_seq.sv
// Sequential single-precision multiplier: 24-cycle shift-add mantissa product,
// round-to-nearest-even, flush-to-zero; unsupported opcodes get an immediate zero reply.
module fpu_mul_seq (
    input logic         clk,
    input logic         rstn,
    fpu_mul_seq_if.slave bus
);

    typedef enum logic [2:0] {IDLE, MUL, ROUND, DONE, REJ} state_e;

    localparam logic [7:0] OP_FMUL = 8'h04;

    state_e       state_q;
    logic [4:0]   cnt_q;
    logic [47:0]  p_q;
    logic         sa_q, sb_q;
    logic [7:0]   ea_q, eb_q;
    logic [23:0]  ma_q, mb_q;
    logic [31:0]  y_q;
    logic         ovf_q, unf_q, vld_q;

    logic [47:0]  addend;
    logic [31:0]  y_d;
    logic         ovf_d, unf_d;

    logic signed [9:0] e;
    logic [22:0]  mant;
    logic [23:0]  mant_inc;
    logic         guard, sticky, s;

    assign addend = mb_q[cnt_q] ? ({24'd0, ma_q} << cnt_q) : '0;

    always_comb begin
        s      = sa_q ^ sb_q;
        e      = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - 10'sd127;
        mant   = p_q[45:23];
        guard  = p_q[22];
        sticky = |p_q[21:0];
        if (p_q[47]) begin
            mant   = p_q[46:24];
            guard  = p_q[23];
            sticky = |p_q[22:0];
            e      = e + 10'sd1;
        end
        mant_inc = {1'b0, mant} + {23'd0, guard & (sticky | mant[0])};
        // carry out of the mantissa leaves mant_inc[22:0] all zero, as required
        if (mant_inc[23]) e = e + 10'sd1;

        y_d   = {s, e[7:0], mant_inc[22:0]};
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (e >= 10'sd255) begin
            y_d   = {s, 8'hFF, 23'h0};
            ovf_d = 1'b1;
        end else if (e <= 10'sd0) begin
            y_d   = {s, 31'h0};
            unf_d = 1'b1;
        end

        if (((ea_q == 8'hFF) && (eb_q == 8'h00)) || ((eb_q == 8'hFF) && (ea_q == 8'h00))) begin
            y_d   = 32'h7FC00000;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else if ((ea_q == 8'hFF) || (eb_q == 8'hFF)) begin
            y_d   = {s, 8'hFF, 23'h0};
            ovf_d = 1'b1;
            unf_d = 1'b0;
        end else if ((ea_q == 8'h00) || (eb_q == 8'h00)) begin
            y_d   = {s, 31'h0};
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            ea_q    <= '0;
            eb_q    <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.opcode == OP_FMUL) begin
                        sa_q    <= bus.x1[31];
                        sb_q    <= bus.x2[31];
                        ea_q    <= bus.x1[30:23];
                        eb_q    <= bus.x2[30:23];
                        ma_q    <= {1'b1, bus.x1[22:0]};
                        mb_q    <= {1'b1, bus.x2[22:0]};
                        p_q     <= '0;
                        cnt_q   <= '0;
                        state_q <= MUL;
                    end else if (bus.opcode != 8'h00) begin
                        y_q     <= '0;
                        ovf_q   <= 1'b0;
                        unf_q   <= 1'b0;
                        vld_q   <= 1'b1;
                        state_q <= REJ;
                    end
                end
                MUL: begin
                    p_q   <= p_q + addend;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd23) state_q <= ROUND;
                end
                ROUND: begin
                    y_q     <= y_d;
                    ovf_q   <= ovf_d;
                    unf_q   <= unf_d;
                    vld_q   <= 1'b1;
                    state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                REJ:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.y         = y_q;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;
    assign bus.out_valid = vld_q;

endmodule
